// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the counter load arbiter.
//   CTR_WIDTH : default counter / start / terminal width
//   state_t   : sequencing FSM states (IDLE -> LOAD -> RUN -> DONE -> IDLE)
package ctrl_pkg;

  localparam int unsigned CTR_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter.
//   req : request per requester (bit i = requester i)
//   ptr : requester favoured when both request (0 or 1)
//   win : one-hot winner, zero when no request
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);

  always_comb begin
    win = '0;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ptr ? 2'b10 : 2'b01;
      default: win = '0;
    endcase
  end

endmodule

// File: rtl/counter_load_arbiter.sv
// counter_load_arbiter: shares one loadable up-counter between two requesters.
// The round-robin winner's start/terminal values are captured, the counter is
// loaded with start and counts up (wrapping) until it equals terminal, then the
// winner's done pulses for one cycle.
//   clk           : rising-edge clock
//   rst           : asynchronous active-low reset
//   req[1:0]      : level requests
//   start0/term0  : start / terminal value for requester 0
//   start1/term1  : start / terminal value for requester 1
//   cancel        : abort the current job in LOAD/RUN (no done)
//   gnt[1:0]      : one-hot grant, held LOAD..DONE
//   done[1:0]     : one-cycle completion pulse to the granted requester
//   busy          : FSM not idle
//   load_en       : counter load strobe (high in LOAD)
//   q             : counter value
module counter_load_arbiter
  import ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CTR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] start0,
  input  logic [WIDTH-1:0] term0,
  input  logic [WIDTH-1:0] start1,
  input  logic [WIDTH-1:0] term1,
  input  logic             cancel,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             load_en,
  output logic [WIDTH-1:0] q
);

  state_t           state, state_nxt;
  logic             ptr;
  logic [1:0]       win;
  logic [1:0]       gnt_r;
  logic [WIDTH-1:0] start_r, term_r, q_r;
  logic             job_end;

  rr_arb2 u_arb (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  always_comb begin
    state_nxt = state;
    job_end   = 1'b0;
    case (state)
      ST_IDLE: if (req != '0) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (cancel) begin
          state_nxt = ST_IDLE;
          job_end   = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      // Cancel takes priority over reaching the terminal value.
      ST_RUN: begin
        if (cancel) begin
          state_nxt = ST_IDLE;
          job_end   = 1'b1;
        end else if (q_r == term_r) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        job_end   = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      ptr     <= 1'b0;
      gnt_r   <= '0;
      start_r <= '0;
      term_r  <= '0;
      q_r     <= '0;
    end else begin
      state <= state_nxt;

      if (state == ST_IDLE && req != '0) begin
        gnt_r   <= win;
        start_r <= win[1] ? start1 : start0;
        term_r  <= win[1] ? term1  : term0;
      end else if (state != ST_IDLE && state_nxt == ST_IDLE) begin
        gnt_r <= '0;
      end

      // Completed or cancelled jobs both hand priority to the other side.
      if (job_end) ptr <= gnt_r[0];

      if (state == ST_LOAD) begin
        q_r <= start_r;
      end else if (state == ST_RUN && !cancel && q_r != term_r) begin
        q_r <= q_r + WIDTH'(1);
      end
    end
  end

  assign gnt     = gnt_r;
  assign done    = (state == ST_DONE) ? gnt_r : 2'b00;
  assign busy    = (state != ST_IDLE);
  assign load_en = (state == ST_LOAD);
  assign q       = q_r;

endmodule

// File: tb/tb_counter_load_arbiter.sv
module tb_counter_load_arbiter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] start0, term0, start1, term1;
  logic         cancel;
  logic [1:0]   gnt, done;
  logic         busy, load_en;
  logic [W-1:0] q;

  int checks = 0;
  int errors = 0;

  counter_load_arbiter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .start0  (start0),
    .term0   (term0),
    .start1  (start1),
    .term1   (term1),
    .cancel  (cancel),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .load_en (load_en),
    .q       (q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  logic [1:0]   g;
  logic [W-1:0] qs;

  initial begin
    rst = 1'b0; req = 2'b00; cancel = 1'b0;
    start0 = '0; term0 = '0; start1 = '0; term1 = '0;
    tick(); tick();
    chk("rst_q", 8'(q), 8'h0);
    chk("rst_gnt", 8'(gnt), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_load_en", 8'(load_en), 8'h0);
    rst = 1'b1;
    tick();

    // Test 1: single job 3..7 for requester 0; req dropped after grant.
    start0 = 4'd3; term0 = 4'd7; req = 2'b01;
    tick();                                   // e1
    chk("t1_gnt_e1", 8'(gnt), 8'h1);
    chk("t1_busy_e1", 8'(busy), 8'h1);
    chk("t1_load_en_e1", 8'(load_en), 8'h1);
    req = 2'b00; start0 = 4'd0; term0 = 4'd0;  // inputs may change after capture
    tick();                                   // e2
    chk("t1_q_e2", 8'(q), 8'h3);
    chk("t1_load_en_e2", 8'(load_en), 8'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();                                 // e3..e6
      chk("t1_q_run", 8'(q), 8'(3 + i));
      chk("t1_done_run", 8'(done), 8'h0);
    end
    tick();                                   // e7
    chk("t1_done_e7", 8'(done), 8'h1);
    chk("t1_gnt_e7", 8'(gnt), 8'h1);
    chk("t1_q_hold_e7", 8'(q), 8'h7);
    tick();                                   // e8
    chk("t1_done_e8", 8'(done), 8'h0);
    chk("t1_gnt_e8", 8'(gnt), 8'h0);
    chk("t1_busy_e8", 8'(busy), 8'h0);

    // Test 2: wrap 14,15,0,1 for requester 1.
    start1 = 4'd14; term1 = 4'd1; req = 2'b10;
    tick();                                   // e1
    chk("t2_gnt_e1", 8'(gnt), 8'h2);
    req = 2'b00;
    tick(); chk("t2_q_e2", 8'(q), 8'he);
    tick(); chk("t2_q_e3", 8'(q), 8'hf);
    tick(); chk("t2_q_e4", 8'(q), 8'h0);
    tick(); chk("t2_q_e5", 8'(q), 8'h1);
    chk("t2_done_e5", 8'(done), 8'h0);
    tick(); chk("t2_done_e6", 8'(done), 8'h2);
    tick();
    chk("t2_done_e7", 8'(done), 8'h0);
    chk("t2_q_idle_hold", 8'(q), 8'h1);

    // Test 3: zero-length job (start == term == 5).
    start0 = 4'd5; term0 = 4'd5; req = 2'b01;
    tick(); chk("t3_gnt_e1", 8'(gnt), 8'h1);
    req = 2'b00;
    tick(); chk("t3_q_e2", 8'(q), 8'h5);
    chk("t3_done_e2", 8'(done), 8'h0);
    tick(); chk("t3_done_e3", 8'(done), 8'h1);
    tick(); chk("t3_busy_e4", 8'(busy), 8'h0);

    // Test 4: both requesting. The last job was requester 0, so requester 1
    // is favoured first: order 1,0,1,0 with one idle cycle between jobs.
    start0 = 4'd2; term0 = 4'd2; start1 = 4'd8; term1 = 4'd8; req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      g  = (j % 2 == 0) ? 2'b10 : 2'b01;
      qs = g[0] ? 4'd2 : 4'd8;
      tick(); chk("t4_gnt", 8'(gnt), 8'(g));
      tick(); chk("t4_q", 8'(q), 8'(qs));
      tick(); chk("t4_done", 8'(done), 8'(g));
      chk("t4_done_gnt", 8'(gnt), 8'(g));
      tick(); chk("t4_idle_gnt", 8'(gnt), 8'h0);
      chk("t4_idle_busy", 8'(busy), 8'h0);
      if (j == 3) req = 2'b00;
    end

    // Test 5: cancel during RUN of job 0, then requester 1 wins.
    start0 = 4'd0; term0 = 4'd10; start1 = 4'd4; term1 = 4'd4; req = 2'b01;
    tick(); chk("t5_gnt_e1", 8'(gnt), 8'h1);
    req = 2'b11;
    tick(); chk("t5_q_e2", 8'(q), 8'h0);
    tick(); chk("t5_q_e3", 8'(q), 8'h1);
    cancel = 1'b1;
    tick();
    chk("t5_cancel_gnt", 8'(gnt), 8'h0);
    chk("t5_cancel_done", 8'(done), 8'h0);
    chk("t5_cancel_busy", 8'(busy), 8'h0);
    cancel = 1'b0;
    tick(); chk("t5_next_gnt", 8'(gnt), 8'h2);
    req = 2'b00;
    tick(); chk("t5_q_job1", 8'(q), 8'h4);
    tick(); chk("t5_done_job1", 8'(done), 8'h2);
    cancel = 1'b1;                             // ignored in DONE
    tick(); chk("t5_after_done_busy", 8'(busy), 8'h0);
    cancel = 1'b0;

    // Cancel coinciding with q == term: no done.
    start0 = 4'd6; term0 = 4'd7; req = 2'b01;
    tick(); chk("t5b_gnt", 8'(gnt), 8'h1);
    req = 2'b00;
    tick(); chk("t5b_q_e2", 8'(q), 8'h6);
    tick(); chk("t5b_q_e3", 8'(q), 8'h7);
    cancel = 1'b1;
    tick();
    chk("t5b_done", 8'(done), 8'h0);
    chk("t5b_gnt_clr", 8'(gnt), 8'h0);
    cancel = 1'b0;

    // Test 6: reset mid-RUN at q=9; pointer returns to favour requester 0.
    start0 = 4'd5; term0 = 4'd12; req = 2'b01;
    tick(); chk("t6_gnt", 8'(gnt), 8'h1);
    for (int i = 0; i < 5; i++) tick();        // e2..e6
    chk("t6_q_pre", 8'(q), 8'h9);
    req = 2'b11;
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_q", 8'(q), 8'h0);
    chk("t6_rst_gnt", 8'(gnt), 8'h0);
    chk("t6_rst_done", 8'(done), 8'h0);
    chk("t6_rst_busy", 8'(busy), 8'h0);
    tick();
    rst = 1'b1;
    tick(); chk("t6_first_gnt", 8'(gnt), 8'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
